vga_fb_arbiter: RTL

Arbiter and scanout sequencer for the VGA frame buffer. It shares one single-port 24-bit pixel SRAM between two requesters: the APB-side pixel writer and a display prefetch engine. The prefetch engine streams the frame in raster order into a small pixel FIFO that feeds the VGA timing/colour path. It sits between the APB VGA slave logic, the frame-buffer SRAM macro and the VGA controller.

---
 rtl/vga_fb_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter
// Shares one single-port pixel SRAM between the APB pixel writer and the
// display prefetch engine. The prefetch engine reads the frame in raster order
// into a small FIFO that feeds the VGA colour path.
//
// Ports:
//   clock, reset        system clock, asynchronous active-low reset
//   scan_en             enables prefetch reads
//   frame_start         one-cycle pulse: flush FIFO, restart at pixel 0
//   wr_valid/wr_ready   APB pixel write request / grant (wr_addr, wr_data)
//   pix_ready/pix_valid display handshake; pix_data is the FIFO head (0 if empty)
//   mem_*               SRAM port; mem_rdata valid one cycle after a read
//   fifo_level          FIFO occupancy
//   underflow           sticky: display consumed while FIFO empty
module vga_fb_arbiter #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int AW         = 19,
    parameter int DW         = 24,
    parameter int FIFO_DEPTH = 16,
    parameter int LOW_WATER  = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          scan_en,
    input  logic                          frame_start,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [AW-1:0]                 wr_addr,
    input  logic [DW-1:0]                 wr_data,
    input  logic                          pix_ready,
    output logic                          pix_valid,
    output logic [DW-1:0]                 pix_data,
    output logic                          mem_en,
    output logic                          mem_we,
    output logic [AW-1:0]                 mem_addr,
    output logic [DW-1:0]                 mem_wdata,
    input  logic [DW-1:0]                 mem_rdata,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underflow
);

    localparam int PW        = $clog2(FIFO_DEPTH);
    localparam int FRAME_PIX = H_ACTIVE * V_ACTIVE;

    typedef enum logic {GNT_READ, GNT_WRITE} grant_e;

    logic [AW-1:0] rd_ptr;
    logic          rd_inflight;
    logic [DW-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] head, tail;
    logic [PW:0]   level;
    grant_e        last_grant;
    logic          underflow_q;

    logic [PW+1:0] credit;
    logic          read_req, urgent, grant_rd, grant_wr, push, pop;

    // An in-flight read already owns a FIFO slot, so full + in-flight never overflows.
    assign credit   = {1'b0, level} + {{(PW+1){1'b0}}, rd_inflight};
    assign read_req = scan_en && !frame_start && (credit < (PW+2)'(FIFO_DEPTH));
    assign urgent   = read_req && (level < (PW+1)'(LOW_WATER));

    // Urgent reads always win; otherwise reads and writes alternate under contention.
    // Grants are masked while reset is held so the SRAM sees no access.
    assign grant_rd = reset && read_req &&
                      (urgent || !wr_valid || last_grant == GNT_WRITE);
    assign grant_wr = reset && wr_valid && !grant_rd;

    assign wr_ready  = grant_wr;
    assign mem_en    = grant_rd || grant_wr;
    assign mem_we    = grant_wr;
    assign mem_addr  = grant_rd ? rd_ptr : (grant_wr ? wr_addr : '0);
    assign mem_wdata = grant_wr ? wr_data : '0;

    assign push = rd_inflight;
    assign pop  = pix_ready && (level != '0);

    assign pix_valid  = (level != '0);
    assign pix_data   = pix_valid ? fifo_mem[head] : '0;
    assign fifo_level = level;
    assign underflow  = underflow_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr      <= '0;
            rd_inflight <= 1'b0;
            head        <= '0;
            tail        <= '0;
            level       <= '0;
            last_grant  <= GNT_WRITE;
            underflow_q <= 1'b0;
        end else begin
            if (grant_rd)      last_grant <= GNT_READ;
            else if (grant_wr) last_grant <= GNT_WRITE;

            if (frame_start) begin
                // Flush; any data returning this cycle is dropped.
                rd_ptr      <= '0;
                rd_inflight <= 1'b0;
                head        <= '0;
                tail        <= '0;
                level       <= '0;
                underflow_q <= 1'b0;
            end else begin
                rd_inflight <= grant_rd;
                if (grant_rd)
                    rd_ptr <= (rd_ptr == AW'(FRAME_PIX - 1)) ? '0 : rd_ptr + AW'(1);
                if (push) tail <= tail + PW'(1);
                if (pop)  head <= head + PW'(1);
                if (push && !pop)      level <= level + (PW+1)'(1);
                else if (pop && !push) level <= level - (PW+1)'(1);
                if (pix_ready && level == '0 && scan_en) underflow_q <= 1'b1;
            end
        end
    end

    // Storage needs no reset: level gates every read of it.
    always_ff @(posedge clock) begin
        if (push && !frame_start) fifo_mem[tail] <= mem_rdata;
    end

endmodule
